ahb3lite_sram_bridge: RTL and testbench
=======================================

Name: ahb3lite_sram_bridge

Overview:
AHB3-Lite slave that converts bus transfers into single-port SRAM accesses (ce/we/oe/waddr/din/sel/dout). It sits directly upstream of the single-port SRAM wrapper, driving its port and returning its read data on HRDATA. Reads and writes are zero-wait-state except on a read-after-write port conflict, which costs one wait state. Out-of-range, oversized and misaligned transfers get a two-cycle ERROR response.

Parameters:
MEM_SIZE_BYTE, 32768, memory size in bytes; byte addresses >= this value get ERROR.
PLEN, 32, HADDR width.
XLEN, 32, data width; only 32 is supported (SW=4).
WORD_AW, PLEN-2, SRAM word-address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
HSEL  in  1  slave select
HADDR  in  PLEN  address
HWDATA  in  XLEN  write data (data phase)
HRDATA  out  XLEN  read data
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type (ignored)
HPROT  in  4  protection (ignored)
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HMASTLOCK  in  1  ignored
HREADY  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_oe  out  1  SRAM output enable
sram_waddr  out  WORD_AW  SRAM word address
sram_din  out  XLEN  SRAM write data
sram_sel  out  4  SRAM byte lanes
sram_dout  in  XLEN  SRAM read data (1-cycle synchronous read)

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sram_ce/we/oe=0. Any pending write or read is discarded.
- Accept condition: HSEL & HREADY & HTRANS[1]. IDLE and BUSY transfers get OKAY with zero wait states and no SRAM access.
- Error checks at accept:
  - HSIZE>2 → ERROR.
  - HADDR >= MEM_SIZE_BYTE → ERROR.
  - Halfword with HADDR[0]=1, or word with HADDR[1:0]!=0 → ERROR.
- Byte lanes from HSIZE/HADDR[1:0]: byte → 1<<a[1:0]; half → 4'b0011<<a[1]*2; word → 4'b1111.
- Word address is HADDR[PLEN-1:2].
- States: IDLE, WR, RD, RD_STALL, ERR1, ERR2.
- Write accept (→WR): register word address and lanes. In the data phase drive sram_ce=1, sram_we=1, waddr=reg, din=HWDATA, sel=reg; HREADYOUT=1.
- Read accept, port free (→RD): same cycle drive sram_ce=1, oe=1, we=0, waddr=HADDR word, sel=lanes. Data phase: HRDATA=sram_dout, HREADYOUT=1.
- Read accepted while in WR (port busy with the write data phase):
  - Write proceeds and the read address is registered.
  - Next cycle (RD_STALL): issue the read, HREADYOUT=0.
  - Following cycle (RD): HRDATA=sram_dout, HREADYOUT=1.
  - Read returns the just-written data (no forwarding needed).
- ERROR: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; then IDLE or the next accepted transfer. No SRAM access occurs for errored transfers.
- A transfer may be accepted in the last cycle of any data phase (WR, RD, ERR2). Back-to-back writes sustain 1 per cycle; back-to-back reads sustain 1 per cycle.
- HRDATA is 0 outside a read data phase.

Decomposition:
- Shared ahb3lite package: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HWORD/WORD, HRESP_OKAY/ERROR constants, and the bridge state enum type.
- One sub-module: ahb3lite_sram_bytesel, combinational HSIZE+HADDR[1:0] → sel[3:0] plus misalign flag.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 → SRAM write waddr=4, sel=1111; read phase HRDATA=0xDEADBEEF, no wait state.
- Byte write 0xAA @0x21 immediately followed by word read @0x20 (write data phase overlaps read address phase) → sel=0010; exactly one HREADYOUT=0 cycle; HRDATA[15:8]=0xAA.
- Halfword read @0x03 → ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1); sram_ce stays 0.
- Word read @MEM_SIZE_BYTE (0x8000) → two-cycle ERROR; next NONSEQ read @0x0 returns OKAY.
- HTRANS=BUSY and IDLE with HSEL=1 → HREADYOUT=1, HRESP=0, sram_ce=0.
- rst=0 asserted in the RD_STALL cycle → next cycle HREADYOUT=1, HRESP=0, sram_ce=0, state IDLE.

Source files
------------

// File: rtl/ahb3lite_sram_bridge_pkg.sv
// Shared definitions for the AHB3-Lite to single-port SRAM bridge:
// AHB encodings for HTRANS/HSIZE/HRESP and the bridge state type.
package ahb3lite_sram_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_STALL,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

endpackage

// File: rtl/ahb3lite_sram_bridge_if.sv
// AHB3-Lite bus signal bundle.
// slave modport : used by the bridge (address/control/write data in,
//                 HRDATA/HREADYOUT/HRESP out).
// master modport: used by whatever drives the bus.
interface ahb3lite_sram_bridge_if #(
    parameter int PLEN = 32,
    parameter int XLEN = 32
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_sram_bytesel.sv
// Byte-lane decode for a 32-bit AHB slave.
// Ports: hsize (transfer size), addr_lo (HADDR[1:0]) -> sel (active byte
// lanes), misalign (halfword/word not naturally aligned).
// Sizes above a word produce sel=0; the caller flags those separately.
module ahb3lite_sram_bytesel
    import ahb3lite_sram_bridge_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] sel,
    output logic       misalign
);

    always_comb begin
        sel      = 4'b0000;
        misalign = 1'b0;
        case (hsize)
            HSIZE_BYTE:  sel = 4'b0001 << addr_lo;
            HSIZE_HWORD: begin
                sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            HSIZE_WORD: begin
                sel      = 4'b1111;
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb3lite_sram_bridge.sv
// AHB3-Lite slave front-end for a single-port SRAM with 1-cycle read.
// Ports: clk, rst (sync, active-low), ahb (AHB3-Lite slave modport),
// sram_ce/we/oe/waddr/din/sel (SRAM port), sram_dout (SRAM read data).
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no data phase in progress
// ST_WR       | write data phase; SRAM written with HWDATA this cycle
// ST_RD       | read data phase; HRDATA returns sram_dout
// ST_RD_STALL | read waiting for the port after a write; read issued now
// ST_ERR1     | first ERROR cycle (HREADYOUT=0)
// ST_ERR2     | second ERROR cycle (HREADYOUT=1)
module ahb3lite_sram_bridge
    import ahb3lite_sram_bridge_pkg::*;
#(
    parameter int MEM_SIZE_BYTE = 32768,
    parameter int PLEN          = 32,
    parameter int XLEN          = 32,
    parameter int WORD_AW       = PLEN - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ahb3lite_sram_bridge_if.slave ahb,
    output logic                 sram_ce,
    output logic                 sram_we,
    output logic                 sram_oe,
    output logic [WORD_AW-1:0]   sram_waddr,
    output logic [XLEN-1:0]      sram_din,
    output logic [3:0]           sram_sel,
    input  logic [XLEN-1:0]      sram_dout
);

    localparam logic [PLEN-1:0] MEM_LIMIT = PLEN'(MEM_SIZE_BYTE);

    bridge_state_t      state_q, state_d;
    logic [WORD_AW-1:0] waddr_q, waddr_d;
    logic [3:0]         sel_q, sel_d;

    logic [3:0]         lane_sel;
    logic               misalign;
    logic [WORD_AW-1:0] addr_word;
    logic               can_accept;
    logic               accept;
    logic               xfer_err;
    logic               rd_now;
    logic               unused_bus;

    ahb3lite_sram_bytesel u_bytesel (
        .hsize    (ahb.HSIZE),
        .addr_lo  (ahb.HADDR[1:0]),
        .sel      (lane_sel),
        .misalign (misalign)
    );

    assign unused_bus = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0]};

    assign addr_word  = WORD_AW'(ahb.HADDR[PLEN-1:2]);
    // Only states with HREADYOUT=1 end a data phase, so only they may
    // take a new address phase; rst gating keeps the SRAM quiet in reset.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                        (state_q == ST_RD)   || (state_q == ST_ERR2);
    assign accept     = rst & can_accept & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign xfer_err   = (ahb.HSIZE > HSIZE_WORD) || (ahb.HADDR >= MEM_LIMIT) || misalign;
    // A read can use the port in its address phase unless a write data
    // phase owns it this cycle.
    assign rd_now     = accept & ~xfer_err & ~ahb.HWRITE & (state_q != ST_WR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        sel_d   = sel_q;
        case (state_q)
            ST_RD_STALL: state_d = ST_RD;
            ST_ERR1:     state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (ahb.HWRITE || state_q == ST_WR) begin
                        state_d = ahb.HWRITE ? ST_WR : ST_RD_STALL;
                        waddr_d = addr_word;
                        sel_d   = lane_sel;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
        endcase
    end

    always_comb begin
        sram_ce       = 1'b0;
        sram_we       = 1'b0;
        sram_oe       = 1'b0;
        sram_waddr    = '0;
        sram_din      = '0;
        sram_sel      = 4'b0000;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = HRESP_OKAY;
        ahb.HRDATA    = '0;
        case (state_q)
            ST_WR: begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_waddr = waddr_q;
                sram_din   = ahb.HWDATA;
                sram_sel   = sel_q;
            end
            ST_RD: ahb.HRDATA = sram_dout;
            ST_RD_STALL: begin
                sram_ce       = 1'b1;
                sram_oe       = 1'b1;
                sram_waddr    = waddr_q;
                sram_sel      = sel_q;
                ahb.HREADYOUT = 1'b0;
            end
            ST_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = HRESP_ERROR;
            end
            ST_ERR2: ahb.HRESP = HRESP_ERROR;
            default: ;
        endcase
        if (rd_now) begin
            sram_ce    = 1'b1;
            sram_oe    = 1'b1;
            sram_waddr = addr_word;
            sram_sel   = lane_sel;
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_bridge.sv
module tb_ahb3lite_sram_bridge;

    logic        clk;
    logic        rst;
    logic        sram_ce, sram_we, sram_oe;
    logic [29:0] sram_waddr;
    logic [31:0] sram_din;
    logic [3:0]  sram_sel;
    logic [31:0] sram_dout;

    int n_cmp = 0;
    int n_err = 0;

    ahb3lite_sram_bridge_if #(.PLEN(32), .XLEN(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb3lite_sram_bridge #(.MEM_SIZE_BYTE(32768), .PLEN(32), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ahb        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_oe    (sram_oe),
        .sram_waddr (sram_waddr),
        .sram_din   (sram_din),
        .sram_sel   (sram_sel),
        .sram_dout  (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple synchronous SRAM: one-cycle read latency, byte-lane writes.
    logic [31:0] sram_mem [0:8191];
    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_sel[b]) sram_mem[sram_waddr[12:0]][b*8 +: 8] <= sram_din[b*8 +: 8];
        end
        if (sram_ce && !sram_we) sram_dout <= sram_mem[sram_waddr[12:0]];
    end

    // Reference byte memory for the random phase.
    logic [7:0] mem_ref [0:32767];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        bus.HSEL   = 1'b1;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
        bus.HADDR  = ad;
        bus.HWDATA = wd;
        #1;
    endtask

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic        exp_ce;
        logic [3:0]  exp_sel;
        logic [29:0] exp_waddr;
    } vec_t;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    function automatic xfer_t gen_xfer();
        xfer_t x;
        x.trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'b10;
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 19) < 18) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
        x.addr  = ($urandom_range(0, 99) < 80) ? 32'h100 + 32'($urandom_range(0, 63))
                                               : 32'h7FF0 + 32'($urandom_range(0, 31));
        x.wdata = $urandom();
        return x;
    endfunction

    function automatic bit ref_err(input xfer_t x);
        int nb;
        if (x.size > 2) return 1'b1;
        if (x.addr >= 32'd32768) return 1'b1;
        nb = 1 << x.size;
        return (x.addr % nb) != 0;
    endfunction

    vec_t vecs[14];

    initial begin
        xfer_t a_ph, d_ph;
        bit    d_valid, d_err, prev_ok_wr, abort;
        int    d_wait, exp_waits, nb, lane;
        logic [31:0] exp_d, mask;

        for (int i = 0; i < 8192; i++) sram_mem[i] = '0;
        for (int i = 0; i < 32768; i++) mem_ref[i] = '0;
        sram_dout     = '0;
        rst           = 1'b0;
        bus.HSEL      = 1'b0;
        bus.HADDR     = '0;
        bus.HWDATA    = '0;
        bus.HWRITE    = 1'b0;
        bus.HSIZE     = 3'd2;
        bus.HBURST    = '0;
        bus.HPROT     = '0;
        bus.HTRANS    = 2'b00;
        bus.HMASTLOCK = 1'b0;

        // hsel, htrans, hwrite, hsize, haddr, exp_ce, exp_sel, exp_waddr
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 3'd2, 32'h10,   1'b0, 4'b0000, 30'h0};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 3'd2, 32'h10,   1'b0, 4'b0000, 30'h0};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 3'd2, 32'h10,   1'b0, 4'b0000, 30'h0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h10,   1'b1, 4'b1111, 30'h4};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 3'd0, 32'h13,   1'b1, 4'b1000, 30'h4};
        vecs[5]  = '{1'b1, 2'b10, 1'b0, 3'd0, 32'h21,   1'b1, 4'b0010, 30'h8};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h22,   1'b1, 4'b1100, 30'h8};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h20,   1'b1, 4'b0011, 30'h8};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 3'd1, 32'h23,   1'b0, 4'b0000, 30'h0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h7FFC, 1'b1, 4'b1111, 30'h1FFF};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 3'd2, 32'h8000, 1'b0, 4'b0000, 30'h0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 3'd3, 32'h0,    1'b0, 4'b0000, 30'h0};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 3'd2, 32'h4,    1'b1, 4'b1111, 30'h1};
        vecs[13] = '{1'b1, 2'b10, 1'b1, 3'd2, 32'h10,   1'b0, 4'b0000, 30'h0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hresp",     32'(bus.HRESP), 32'd0);
        chk("rst_hrdata",    bus.HRDATA, 32'd0);
        chk("rst_ce_we_oe",  32'({sram_ce, sram_we, sram_oe}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Address-phase decode from idle, one vector at a time
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.HSEL   = vecs[i].hsel;
            bus.HTRANS = vecs[i].htrans;
            bus.HWRITE = vecs[i].hwrite;
            bus.HSIZE  = vecs[i].hsize;
            bus.HADDR  = vecs[i].haddr;
            bus.HWDATA = '0;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);
            chk($sformatf("vec%0d_ce", i), 32'(sram_ce), 32'(vecs[i].exp_ce));
            if (vecs[i].exp_ce) begin
                chk($sformatf("vec%0d_sel", i), 32'(sram_sel), 32'(vecs[i].exp_sel));
                chk($sformatf("vec%0d_waddr", i), 32'(sram_waddr), 32'(vecs[i].exp_waddr));
                chk($sformatf("vec%0d_we_oe", i), 32'({sram_we, sram_oe}), 32'b01);
            end
            step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
            step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
            step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        end

        // Word write then (after idle) word read, no wait state
        step(2'b10, 1'b1, 3'd2, 32'h10, 32'h0);
        chk("s1_addr_ce", 32'(sram_ce), 32'd0);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF);
        chk("s1_wr_ctl", 32'({sram_ce, sram_we, bus.HREADYOUT}), 32'b111);
        chk("s1_wr_waddr", 32'(sram_waddr), 32'd4);
        chk("s1_wr_sel", 32'(sram_sel), 32'hF);
        chk("s1_wr_din", sram_din, 32'hDEADBEEF);
        step(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("s1_rd_issue", 32'({sram_ce, sram_oe, sram_we, bus.HREADYOUT}), 32'b1101);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s1_rd_ready", 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);
        chk("s1_rd_data", bus.HRDATA, 32'hDEADBEEF);

        // Byte write immediately followed by word read: one stall cycle
        step(2'b10, 1'b1, 3'd0, 32'h21, 32'h0);
        step(2'b10, 1'b0, 3'd2, 32'h20, 32'h0000AA00);
        chk("s2_wr_sel", 32'(sram_sel), 32'b0010);
        chk("s2_wr_ctl", 32'({sram_ce, sram_we, bus.HREADYOUT}), 32'b111);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s2_stall_ready", 32'(bus.HREADYOUT), 32'd0);
        chk("s2_stall_rd", 32'({sram_ce, sram_oe, sram_we}), 32'b110);
        chk("s2_stall_waddr", 32'(sram_waddr), 32'd8);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s2_rd_ready", 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);
        chk("s2_rd_byte1", 32'(bus.HRDATA[15:8]), 32'hAA);

        // Misaligned halfword read: two-cycle ERROR, no SRAM access
        step(2'b10, 1'b0, 3'd1, 32'h3, 32'h0);
        chk("s3_addr_ce", 32'(sram_ce), 32'd0);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s3_err1", 32'({bus.HREADYOUT, bus.HRESP, sram_ce}), 32'b010);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s3_err2", 32'({bus.HREADYOUT, bus.HRESP, sram_ce}), 32'b110);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s3_after", 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);

        // Out-of-range read, then a read accepted during ERR2
        step(2'b10, 1'b0, 3'd2, 32'h8000, 32'h0);
        chk("s4_addr_ce", 32'(sram_ce), 32'd0);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s4_err1", 32'({bus.HREADYOUT, bus.HRESP, sram_ce}), 32'b010);
        step(2'b10, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s4_err2", 32'({bus.HREADYOUT, bus.HRESP}), 32'b11);
        chk("s4_next_issue", 32'({sram_ce, sram_oe}), 32'b11);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s4_next_okay", 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);
        chk("s4_next_data", bus.HRDATA, 32'h0);

        // Reset asserted during RD_STALL
        step(2'b10, 1'b1, 3'd2, 32'h40, 32'h0);
        step(2'b10, 1'b0, 3'd2, 32'h40, 32'h12345678);
        step(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
        chk("s6_stall", 32'(bus.HREADYOUT), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_after_rst", 32'({bus.HREADYOUT, bus.HRESP, sram_ce}), 32'b100);
        chk("s6_after_rst_data", bus.HRDATA, 32'h0);

        // Randomized pipelined traffic against a byte-level reference memory
        d_valid = 1'b0;
        d_err   = 1'b0;
        d_wait  = 0;
        exp_waits = 0;
        abort   = 1'b0;
        d_ph    = gen_xfer();
        a_ph    = gen_xfer();
        for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
            @(negedge clk);
            bus.HSEL   = 1'b1;
            bus.HTRANS = a_ph.trans;
            bus.HWRITE = a_ph.write;
            bus.HSIZE  = a_ph.size;
            bus.HADDR  = a_ph.addr;
            bus.HWDATA = (d_valid && d_ph.write) ? d_ph.wdata : $urandom();
            #1;
            prev_ok_wr = 1'b0;
            if (d_valid) begin
                if (!bus.HREADYOUT) begin
                    d_wait++;
                    if (d_err) begin
                        chk("rnd_err1_resp", 32'(bus.HRESP), 32'd1);
                        chk("rnd_err1_ce", 32'(sram_ce), 32'd0);
                    end else begin
                        chk("rnd_stall_resp", 32'(bus.HRESP), 32'd0);
                    end
                    if (d_wait > 3) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rnd_timeout: got %0d wait states expected at most %0d", d_wait, exp_waits);
                        abort = 1'b1;
                    end
                end else begin
                    chk("rnd_resp", 32'(bus.HRESP), 32'(d_err));
                    chk("rnd_waits", 32'(d_wait), 32'(exp_waits));
                    if (!d_err && !d_ph.write) begin
                        nb = 1 << d_ph.size;
                        exp_d = '0;
                        mask  = '0;
                        for (int k = 0; k < nb; k++) begin
                            lane = int'(d_ph.addr % 4) + k;
                            mask[lane*8 +: 8]  = 8'hFF;
                            exp_d[lane*8 +: 8] = mem_ref[d_ph.addr + k];
                        end
                        chk("rnd_rdata", bus.HRDATA & mask, exp_d);
                    end else begin
                        chk("rnd_hrdata_zero", bus.HRDATA, 32'h0);
                    end
                    if (!d_err && d_ph.write) begin
                        nb = 1 << d_ph.size;
                        for (int k = 0; k < nb; k++) begin
                            lane = int'(d_ph.addr % 4) + k;
                            mem_ref[d_ph.addr + k] = d_ph.wdata[lane*8 +: 8];
                        end
                        prev_ok_wr = 1'b1;
                    end
                    d_valid = 1'b0;
                end
            end else begin
                chk("rnd_idle_resp", 32'({bus.HREADYOUT, bus.HRESP}), 32'b10);
                chk("rnd_idle_hrdata", bus.HRDATA, 32'h0);
            end
            if (bus.HREADYOUT) begin
                if (a_ph.trans[1]) begin
                    d_ph      = a_ph;
                    d_valid   = 1'b1;
                    d_wait    = 0;
                    d_err     = ref_err(a_ph);
                    exp_waits = (d_err || (!a_ph.write && prev_ok_wr)) ? 1 : 0;
                end
                a_ph = gen_xfer();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
